// File: rtl/mmio_decode.sv
// MMIO address decoder: RAM / keyboard+display I/O page / wait-stated ROM.
// Define MMIO_DECODE_KBD_FIFO_EN to buffer the keyboard in a 4-entry FIFO.
module mmio_decode #(
   parameter logic [15:0] RAM_TOP  = 16'hB000,
   parameter logic [11:0] IO_PAGE  = 12'hC01,
   parameter int unsigned ROM_WAIT = 1
) (
   input  logic        phi,
   input  logic        rst_n,
   input  logic [15:0] cpu_adr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_dbo,
   output logic [7:0]  cpu_dbi,
   output logic        cpu_rdy,
   input  logic [7:0]  ram_dbo,
   input  logic [7:0]  rom_dbo,
   output logic        ram_we,
   input  logic [6:0]  kbd_data,
   input  logic        kbd_stb,
   output logic [6:0]  dsp_data,
   output logic        dsp_wr,
   input  logic        dsp_ack
);

   localparam int unsigned WCNT_W     = 3;
   localparam logic [WCNT_W-1:0] ROM_WAIT_C = WCNT_W'(ROM_WAIT);

   logic              ram_sel, io_sel, rom_sel, rom_stall, acc;
   logic              io_rd, io_wr, kbd_pop, cr_rd, dsp_ld;
   logic [1:0]        off;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [7:0]        cpu_dbi_q, cpu_dbi_d, rd_data;
   logic              dsp_busy_q, dsp_busy_d, dsp_wr_q, dsp_wr_d;
   logic [6:0]        dsp_data_q, dsp_data_d;
   logic              ovr_q, ovr_d, ovr_set;
   logic              kbd_rdy;
   logic [6:0]        kbd_char;
   logic              unused_ok;

   assign unused_ok = &{1'b0, cpu_dbo[7], cpu_adr[3:2]};

   // Address decode, stall and accept qualification
   always_comb begin
      ram_sel   = cpu_adr < RAM_TOP;
      io_sel    = !ram_sel && (cpu_adr[15:4] == IO_PAGE);
      rom_sel   = !ram_sel && !io_sel;
      rom_stall = rom_sel && (wcnt_q != ROM_WAIT_C);
      acc       = rst_n && !rom_stall;
      cpu_rdy   = !rst_n || !rom_stall;
      ram_we    = acc && cpu_we && ram_sel;
      off       = cpu_adr[1:0];
      io_rd     = acc && io_sel && !cpu_we;
      io_wr     = acc && io_sel && cpu_we;
      kbd_pop   = io_rd && (off == 2'd0);
      cr_rd     = io_rd && (off == 2'd1);
      dsp_ld    = io_wr && (off == 2'd2) && !dsp_busy_q;
   end

   // Read mux, wait counter and display next state
   always_comb begin
      rd_data = 8'h00;
      if (ram_sel) begin
         rd_data = ram_dbo;
      end else if (rom_sel) begin
         rd_data = rom_dbo;
      end else begin
         case (off)
            2'd0:    rd_data = {1'b1, kbd_char};
            2'd1:    rd_data = {kbd_rdy, ovr_q, 6'b0};
            2'd2:    rd_data = {dsp_busy_q, 7'b0};
            default: rd_data = 8'h00;
         endcase
      end
      cpu_dbi_d  = acc ? rd_data : cpu_dbi_q;
      wcnt_d     = rom_stall ? wcnt_q + WCNT_W'(1) : '0;
      dsp_wr_d   = dsp_ld;
      dsp_data_d = dsp_ld ? cpu_dbo[6:0] : dsp_data_q;
      dsp_busy_d = dsp_busy_q;
      if (dsp_ld)                   dsp_busy_d = 1'b1;
      else if (dsp_busy_q && dsp_ack) dsp_busy_d = 1'b0;
      ovr_d = ovr_q;
      if (cr_rd)   ovr_d = 1'b0;
      if (ovr_set) ovr_d = 1'b1;
   end

   always_ff @(posedge phi) begin
      if (!rst_n) begin
         cpu_dbi_q  <= 8'h00;
         wcnt_q     <= '0;
         dsp_busy_q <= 1'b0;
         dsp_wr_q   <= 1'b0;
         dsp_data_q <= 7'h00;
         ovr_q      <= 1'b0;
      end else begin
         cpu_dbi_q  <= cpu_dbi_d;
         wcnt_q     <= wcnt_d;
         dsp_busy_q <= dsp_busy_d;
         dsp_wr_q   <= dsp_wr_d;
         dsp_data_q <= dsp_data_d;
         ovr_q      <= ovr_d;
      end
   end

`ifdef MMIO_DECODE_KBD_FIFO_EN
   localparam int unsigned CNT_W = 3;
   logic [6:0]       fifo_q [4];
   logic [1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty, full, pop, push;

   always_comb begin
      empty    = cnt_q == CNT_W'(0);
      full     = cnt_q == CNT_W'(4);
      pop      = kbd_pop && !empty;
      push     = kbd_stb && (!full || pop);
      ovr_set  = kbd_stb && full && !pop;
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      kbd_rdy  = !empty;
      kbd_char = fifo_q[rd_ptr_q];
   end

   always_ff @(posedge phi) begin
      if (!rst_n) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; only the pointers define validity
   always_ff @(posedge phi) begin
      if (push) fifo_q[wr_ptr_q] <= kbd_data;
   end
`else
   logic       kbd_rdy_q, kbd_rdy_d;
   logic [6:0] char_q, char_d;

   // A strobe coinciding with a KBD read replaces the char being consumed
   always_comb begin
      kbd_rdy_d = kbd_rdy_q;
      char_d    = char_q;
      ovr_set   = 1'b0;
      if (kbd_stb) begin
         char_d    = kbd_data;
         kbd_rdy_d = 1'b1;
         ovr_set   = kbd_rdy_q && !kbd_pop;
      end else if (kbd_pop) begin
         kbd_rdy_d = 1'b0;
      end
      kbd_rdy  = kbd_rdy_q;
      kbd_char = char_q;
   end

   always_ff @(posedge phi) begin
      if (!rst_n) begin
         kbd_rdy_q <= 1'b0;
         char_q    <= 7'h00;
      end else begin
         kbd_rdy_q <= kbd_rdy_d;
         char_q    <= char_d;
      end
   end
`endif

   assign cpu_dbi  = cpu_dbi_q;
   assign dsp_data = dsp_data_q;
   assign dsp_wr   = dsp_wr_q;

endmodule
